// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: on a miss, fetches the four words of the
// 16-byte line in order, presents the assembled line for one cycle, then releases the stall.
module icache_refill #(
  parameter int MAX_WAIT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  input  logic [31:0]  address,
  input  logic         hit,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic [31:0]  mem_rdata,
  output logic [127:0] dataline,
  output logic         line_valid,
  output logic         stall,
  output logic         err
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, FILL, SETTLE, ERROR} state_t;

  state_t          state_q, state_d;
  logic [27:0]     line_q, line_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [3:0][31:0] lbuf_q, lbuf_d;

  logic            mem_req_d, line_valid_d, stall_d, err_d;
  logic [31:0]     mem_addr_d;
  logic [127:0]    dataline_d;

  // Byte offset inside the line is irrelevant: the whole line is always fetched.
  logic unused_addr_lo;
  assign unused_addr_lo = ^address[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      lbuf_q     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      dataline   <= '0;
      line_valid <= 1'b0;
      stall      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      lbuf_q     <= lbuf_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      dataline   <= dataline_d;
      line_valid <= line_valid_d;
      stall      <= stall_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    lbuf_d  = lbuf_q;
    case (state_q)
      IDLE: if (fetch_en && !hit) begin
        state_d = FETCH;
        line_d  = address[31:4];
        cnt_d   = '0;
        wait_d  = '0;
      end
      FETCH: begin
        if (mem_ready) begin
          lbuf_d[cnt_q] = mem_rdata;
          cnt_d         = cnt_q + 2'd1;
          wait_d        = '0;
          if (cnt_q == 2'd3) state_d = FILL;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WW'(MAX_WAIT - 1)) state_d = ERROR;
        end
      end
      FILL:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = ERROR;
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    mem_req_d    = (state_d == FETCH);
    mem_addr_d   = (state_d == FETCH) ? {line_d, cnt_d, 2'b00} : 32'h0;
    line_valid_d = (state_d == FILL);
    stall_d      = (state_d != IDLE);
    err_d        = (state_d == ERROR);
    dataline_d   = (state_d == FILL) ? lbuf_d : dataline;
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: nominal and throttled refills, idle behaviour,
// address changes mid-refill, memory timeout and reset during a refill.
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fetch_en = 1'b0;
  logic [31:0]  address = 32'h0;
  logic         hit = 1'b0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;
  logic [127:0] dataline;
  logic         line_valid;
  logic         stall;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] LINE_EXP = 128'h000000A3_000000A2_000000A1_000000A0;

  icache_refill #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .address(address), .hit(hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dataline(dataline), .line_valid(line_valid), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; fetch_en = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fetch_en = 1'b1; hit = 1'b0; address = 32'h124;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else n_pass++;
    n_chk++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else n_pass++;
    n_chk++; if (dataline !== 128'h0) $display("FAIL reset_dataline got %h exp 0", dataline); else n_pass++;
    n_chk++; if (line_valid !== 1'b0) $display("FAIL reset_line_valid got %b exp 0", line_valid); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    fetch_en = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // One miss on line 0x120; memory answers every p-th requesting cycle.
  task automatic run_miss(input int p, input bit chg, input string tag);
    int k = 0, rq = 0, st = 0, lv = 0, bad = 0, cyc = 0;
    logic [31:0]  ad [4];
    logic [127:0] dl = '0;
    for (int i = 0; i < 4; i++) ad[i] = 32'h0;
    @(negedge clk);
    fetch_en = 1'b1; hit = 1'b0; address = 32'h124; mem_ready = 1'b0;
    @(negedge clk);
    fetch_en = 1'b0;
    while (cyc < 60) begin
      if (stall) st++;
      if (mem_req) rq++;
      if (line_valid) begin lv++; dl = dataline; end
      if (mem_req && mem_addr !== 32'(32'h120 + 4 * k)) bad++;
      mem_ready = mem_req && (rq % p == 0);
      if (mem_ready) begin
        if (k < 4) ad[k] = mem_addr;
        mem_rdata = 32'hA0 + 32'(k);
        k++;
      end
      if (chg && rq == 2) address = 32'hFF0;
      if (!stall && st > 0) break;
      cyc++;
      @(negedge clk);
    end
    mem_ready = 1'b0; address = 32'h124;
    n_chk++; if (cyc >= 60) $display("FAIL %s_timeout refill did not finish in %0d cycles", tag, cyc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (ad[i] !== 32'(32'h120 + 4 * i)) $display("FAIL %s_addr%0d got %h exp %h", tag, i, ad[i], 32'h120 + 4 * i);
      else n_pass++;
    end
    n_chk++; if (bad != 0) $display("FAIL %s_addr_hold got %0d bad cycles exp 0", tag, bad); else n_pass++;
    n_chk++; if (k != 4) $display("FAIL %s_words got %0d exp 4", tag, k); else n_pass++;
    n_chk++; if (dl !== LINE_EXP) $display("FAIL %s_dataline got %h exp %h", tag, dl, LINE_EXP); else n_pass++;
    n_chk++; if (lv != 1) $display("FAIL %s_line_valid got %0d pulses exp 1", tag, lv); else n_pass++;
    n_chk++; if (st != (p == 1 ? 6 : 14)) $display("FAIL %s_stall got %0d exp %0d", tag, st, p == 1 ? 6 : 14); else n_pass++;
    n_chk++; if (rq != (p == 1 ? 4 : 12)) $display("FAIL %s_mem_req got %0d exp %0d", tag, rq, p == 1 ? 4 : 12); else n_pass++;
    n_chk++; if (dataline !== LINE_EXP) $display("FAIL %s_dataline_hold got %h exp %h", tag, dataline, LINE_EXP); else n_pass++;
  endtask

  task automatic test_refill();      run_miss(1, 1'b0, "refill"); endtask
  task automatic test_slow_memory(); run_miss(3, 1'b0, "slow");   endtask
  task automatic test_addr_change(); run_miss(1, 1'b1, "addrchg"); endtask

  task automatic test_idle();
    int act_hit = 0, act_dis = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req || stall || line_valid) begin
        if (i <= 10) act_hit++; else act_dis++;
      end
      fetch_en = (i < 10);
      hit      = (i < 10);
      address  = 32'h200 + 32'(16 * i);
      mem_ready = i[0];
    end
    @(negedge clk);
    if (mem_req || stall || line_valid) act_dis++;
    mem_ready = 1'b0; fetch_en = 1'b0; hit = 1'b0;
    n_chk++; if (act_hit != 0) $display("FAIL idle_hit got %0d active cycles exp 0", act_hit); else n_pass++;
    n_chk++; if (act_dis != 0) $display("FAIL idle_disabled got %0d active cycles exp 0", act_dis); else n_pass++;
  endtask

  task automatic test_timeout();
    int rq = 0, cyc = 0, drift = 0;
    do_reset();
    @(negedge clk);
    fetch_en = 1'b1; hit = 1'b0; address = 32'h124; mem_ready = 1'b0;
    @(negedge clk);
    fetch_en = 1'b0;
    while (mem_req && cyc < 20) begin rq++; cyc++; @(negedge clk); end
    n_chk++; if (rq != 4) $display("FAIL timeout_req_cycles got %0d exp 4", rq); else n_pass++;
    n_chk++; if (err !== 1'b1) $display("FAIL timeout_err got %b exp 1", err); else n_pass++;
    n_chk++; if (stall !== 1'b1) $display("FAIL timeout_stall got %b exp 1", stall); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      fetch_en = i[0]; hit = 1'b0; mem_ready = i[1];
      @(negedge clk);
      if (err !== 1'b1 || stall !== 1'b1 || mem_req !== 1'b0) drift++;
    end
    mem_ready = 1'b0; fetch_en = 1'b0;
    n_chk++; if (drift != 0) $display("FAIL timeout_sticky got %0d bad cycles exp 0", drift); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (err !== 1'b0) $display("FAIL timeout_reset_err got %b exp 0", err); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL timeout_reset_stall got %b exp 0", stall); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k = 0, cyc = 0, lv = 0;
    do_reset();
    @(negedge clk);
    fetch_en = 1'b1; hit = 1'b0; address = 32'h124;
    @(negedge clk);
    fetch_en = 1'b0;
    while (k < 3 && cyc < 20) begin
      if (line_valid) lv++;
      mem_ready = mem_req;
      if (mem_ready) begin mem_rdata = 32'hB0 + 32'(k); k++; end
      cyc++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    n_chk++; if (mem_addr !== 32'h12C) $display("FAIL midreset_pre_addr got %h exp 12c", mem_addr); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0 || stall !== 1'b0 || line_valid !== 1'b0 || err !== 1'b0)
      $display("FAIL midreset_ctrl got req=%b stall=%b lv=%b err=%b exp all 0", mem_req, stall, line_valid, err);
    else n_pass++;
    n_chk++; if (mem_addr !== 32'h0) $display("FAIL midreset_addr got %h exp 0", mem_addr); else n_pass++;
    n_chk++; if (lv != 0 || dataline !== 128'h0) $display("FAIL midreset_line got lv=%0d dataline=%h exp none", lv, dataline); else n_pass++;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    run_miss(1, 1'b0, "postreset");
  endtask

  initial begin
    test_reset();
    test_refill();
    test_slow_memory();
    test_idle();
    test_addr_change();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
